gate_tester: RTL
================

Name: gate_tester

Overview:
- Self-checking stimulus/response engine for the 2-input gate library.
- It is the driving and checking end of a gate's a/b/y interface. It drives `dut_a`/`dut_b` through all four input combinations and samples `dut_y` after a settle window.
- It builds the observed truth table and compares it against the expected table for the selected function.
- Used on-board: switches feed `start`/`func_sel`; LEDs show `done`/`pass`/`fail_vec`.

Parameters:
- SETTLE_CYCLES, 2, clock cycles between applying an input combo and sampling `dut_y`. Legal range 1..255.
- CNT_W, 8, width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request, sampled in IDLE or DONE.
- func_sel  input  3  gate function under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 BUF_A.
- dut_a  output  1  stimulus to gate input a.
- dut_b  output  1  stimulus to gate input b.
- dut_y  input  1  gate output being checked.
- busy  output  1  high while a run is in progress.
- done  output  1  high (level) while results are valid.
- pass  output  1  observed table equals expected table; valid when done=1.
- tt_obs  output  4  observed truth table, bit index = {a,b}.
- fail_vec  output  4  tt_obs XOR expected; a 1 marks a failing combo.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, tt_obs=0, fail_vec=0. Internal idx=0, cnt=0, func_q=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → next edge: func_q<=func_sel, idx<=0, {dut_a,dut_b}<=2'b00, cnt<=0, tt_obs<=0, done<=0, enter SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1 → SAMPLE.
  - Occupies exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - tt_obs[idx]<=dut_y.
  - If idx==3 → DONE.
  - Otherwise: idx<=idx+1, {dut_a,dut_b}<=idx+1, cnt<=0, → SETTLE.
- DONE:
  - done=1; pass and fail_vec registered from the final tt_obs.
  - dut_a/dut_b hold 1,1.
  - start=1 restarts exactly as from IDLE; results clear on that edge.
- busy=1 in SETTLE and SAMPLE only.
- start and func_sel are ignored while busy. func_sel changes mid-run have no effect because func_q is latched at start.
- Latency: each combo takes SETTLE_CYCLES+1 cycles. done rises 4*(SETTLE_CYCLES+1)+1 edges after the start-accept edge. With default 2: 13 edges.
- Expected tables (bit3..bit0 = combos 11,10,01,00):
  - AND 1000, OR 1110, NAND 0111, NOR 0001, XOR 0110, XNOR 1001, NOT_A 0011, BUF_A 1100.
- pass = (fail_vec == 0).
- Reset asserted mid-run: immediate return to reset values; no partial results retained.
- start held high continuously: the block reruns immediately after each DONE cycle. DONE lasts one cycle in this case.
- dut_y is sampled raw in SAMPLE. The external gate is combinational, so SETTLE_CYCLES>=1 guarantees stability.

Optional Feature:
- Macro: GATE_TESTER_SYNC_EN.
- Defined:
  - dut_y passes through a 2-flop synchronizer before sampling. This is for off-chip or asynchronous DUT paths.
  - The effective settle window is SETTLE_CYCLES+2. The extra 2 cycles are added inside SETTLE.
  - done latency becomes 4*(SETTLE_CYCLES+3)+1 edges.
  - Synchronizer flops reset to 0.
- Undefined: dut_y is sampled directly, with the latency given above.

Decomposition:
- Package gate_tester_pkg holds:
  - func_sel codes (FUNC_AND..FUNC_BUF_A);
  - the 8-entry expected-truth-table constant array;
  - the state encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3).
- Sub-module gate_tt_lut: combinational, func_q[2:0] → expected[3:0]. Shared with future testers.

Test Plan:
- Real NAND DUT, func_sel=2, pulse start → done after 13 edges; tt_obs=0111, fail_vec=0000, pass=1; dut_a/dut_b sequence 00,01,10,11, each held 3 cycles.
- DUT wired as AND, func_sel=2 (NAND) → tt_obs=1000, fail_vec=1111, pass=0.
- dut_y stuck at 1, func_sel=1 (OR) → tt_obs=1111, fail_vec=0001, pass=0.
- rst_n pulsed low during 3rd combo → outputs return to zero asynchronously; a subsequent start with a NOR DUT and func_sel=3 gives tt_obs=0001, pass=1.
- start re-pulsed while busy and func_sel changed mid-run → run unaffected, result matches the func_sel latched at start. Restart from DONE clears done on the accept edge.
- GATE_TESTER_SYNC_EN defined, XOR DUT, func_sel=4 → done after 21 edges; tt_obs=0110, pass=1.

Source files
------------

// File: rtl/gate_tester_pkg.sv
// Shared definitions for the 2-input gate tester: function codes, expected
// truth tables (bit index = {a,b}) and the FSM state encoding.
package gate_tester_pkg;

  localparam logic [2:0] FUNC_AND   = 3'd0;
  localparam logic [2:0] FUNC_OR    = 3'd1;
  localparam logic [2:0] FUNC_NAND  = 3'd2;
  localparam logic [2:0] FUNC_NOR   = 3'd3;
  localparam logic [2:0] FUNC_XOR   = 3'd4;
  localparam logic [2:0] FUNC_XNOR  = 3'd5;
  localparam logic [2:0] FUNC_NOT_A = 3'd6;
  localparam logic [2:0] FUNC_BUF_A = 3'd7;

  // Indexed by function code; bit3..bit0 = combos 11,10,01,00.
  localparam logic [3:0] EXP_TT [8] = '{
    4'b1000,  // AND
    4'b1110,  // OR
    4'b0111,  // NAND
    4'b0001,  // NOR
    4'b0110,  // XOR
    4'b1001,  // XNOR
    4'b0011,  // NOT_A
    4'b1100   // BUF_A
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gate_tt_lut.sv
// Combinational lookup from a gate function code to its expected truth table.
module gate_tt_lut
  import gate_tester_pkg::*;
(
  input  logic [2:0] func_q,
  output logic [3:0] expected
);

  always_comb begin
    expected = EXP_TT[func_q];
  end

endmodule

// File: rtl/gate_tester.sv
// Stimulus/response engine that walks a 2-input gate through all four input
// combos and checks the result. Optional macro GATE_TESTER_SYNC_EN adds a
// 2-flop synchronizer on dut_y and stretches each settle window by 2 cycles.
//
// Handshake: start is a level request accepted on any edge where the FSM is
// in IDLE or DONE; while busy=1 start/func_sel are ignored. done is a level
// that stays high until the next accepted start or reset.
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func_sel,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] tt_obs,
  output logic [3:0] fail_vec,
  output logic [1:0] state_dbg
);

`ifdef GATE_TESTER_SYNC_EN
  localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
`else
  localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_LEN - 1);

  state_t           state, state_nxt;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       func_q;
  logic [3:0]       expected;
  logic             y_smp;
  logic             accept;

`ifdef GATE_TESTER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], dut_y};
    end
  end

  assign y_smp = sync_q[1];
`else
  assign y_smp = dut_y;
`endif

  gate_tt_lut u_lut (
    .func_q   (func_q),
    .expected (expected)
  );

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == SETTLE_END) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (idx == 2'd3) ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (start) state_nxt = ST_SETTLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_SETTLE) || (state == ST_SAMPLE);
    state_dbg = state;
  end

  // Results are published one cycle into DONE, once tt_obs holds all 4 combos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 2'd0;
      cnt      <= '0;
      func_q   <= 3'd0;
      dut_a    <= 1'b0;
      dut_b    <= 1'b0;
      tt_obs   <= 4'd0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= 4'd0;
    end else if (accept) begin
      func_q         <= func_sel;
      idx            <= 2'd0;
      {dut_a, dut_b} <= 2'b00;
      cnt            <= '0;
      tt_obs         <= 4'd0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_vec       <= 4'd0;
    end else begin
      case (state)
        ST_SETTLE: cnt <= cnt + 1'b1;
        ST_SAMPLE: begin
          tt_obs[idx] <= y_smp;
          if (idx != 2'd3) begin
            idx            <= idx + 2'd1;
            {dut_a, dut_b} <= idx + 2'd1;
            cnt            <= '0;
          end
        end
        ST_DONE: begin
          done     <= 1'b1;
          fail_vec <= tt_obs ^ expected;
          pass     <= (tt_obs == expected);
        end
        default: ;
      endcase
    end
  end

endmodule
